// File: rtl/type_lookup_pkg.sv
// Shared geometry, rule record and config FSM encoding for the type lookup pipeline.
package type_lookup_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TYPE_NUM         = 4;
  localparam int TYPE_WIDTH       = 16;
  localparam int KEY_FIELD_NUM    = 8;
  localparam int KEY_OFFSET_WIDTH = 6;
  localparam int META_CANDI_NUM   = 8;
  localparam int REP_OFFSET_WIDTH = 3;
  localparam int HEAD_SHIFT_WIDTH = 6;
  localparam int META_SHIFT_WIDTH = 6;

  localparam int TYPE_VEC_W  = TYPE_NUM * TYPE_WIDTH;
  localparam int KEY_ENTRY_W = KEY_OFFSET_WIDTH + 1;
  localparam int KEY_VEC_W   = KEY_FIELD_NUM * KEY_ENTRY_W;
  localparam int REP_ENTRY_W = REP_OFFSET_WIDTH + 1;
  localparam int REP_VEC_W   = META_CANDI_NUM * REP_ENTRY_W;
  localparam int MERGE_W     = idx_w(META_CANDI_NUM);
  localparam int MERGE_VEC_W = KEY_FIELD_NUM * MERGE_W;

  typedef struct packed {
    logic                        valid;
    logic [TYPE_VEC_W-1:0]       type_data;
    logic [TYPE_VEC_W-1:0]       type_mask;
    logic [KEY_VEC_W-1:0]        key_offset;
    logic [REP_VEC_W-1:0]        replace_offset;
    logic [HEAD_SHIFT_WIDTH-1:0] head_shift;
    logic [META_SHIFT_WIDTH-1:0] meta_shift;
  } rule_t;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_DRAIN = 2'd1,
    CFG_WRITE = 2'd2
  } cfg_state_t;

  // Candidate j collects {valid bit, field index} of every key field merged into it.
  function automatic logic [REP_VEC_W-1:0] build_replace(
    input logic [KEY_VEC_W-1:0]   key_vec,
    input logic [MERGE_VEC_W-1:0] merge_vec
  );
    logic [REP_VEC_W-1:0] rep;
    rep = '0;
    for (int j = 0; j < META_CANDI_NUM; j++) begin
      for (int k = 0; k < KEY_FIELD_NUM; k++) begin
        if (int'(merge_vec[k*MERGE_W +: MERGE_W]) == j) begin
          rep[j*REP_ENTRY_W +: REP_ENTRY_W] = rep[j*REP_ENTRY_W +: REP_ENTRY_W]
            | {key_vec[k*KEY_ENTRY_W + KEY_OFFSET_WIDTH], REP_OFFSET_WIDTH'(k)};
        end
      end
    end
    return rep;
  endfunction

endpackage

// File: rtl/type_lookup_prio_enc.sv
// Lowest-index-wins encoder over the rule hit vector.
module type_lookup_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  hit,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/type_lookup_pipe.sv
// Two-stage ternary type lookup with tagged valid/ready handshake, hit counters and
// a drain-then-commit rule write path.
module type_lookup_pipe
  import type_lookup_pkg::*;
#(
  parameter int RULE_NUM      = 8,
  parameter int TAG_WIDTH     = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int PRIORITY_MODE = 1,
  localparam int IDX_W  = idx_w(RULE_NUM),
  localparam int CNT_AW = idx_w(RULE_NUM + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [TYPE_VEC_W-1:0]       i_req_type,
  input  logic [TAG_WIDTH-1:0]        i_req_tag,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [TAG_WIDTH-1:0]        o_rsp_tag,
  output logic                        o_rsp_hit,
  output logic [IDX_W-1:0]            o_rsp_ruleIdx,
  output logic [KEY_VEC_W-1:0]        o_rsp_keyOffset,
  output logic [HEAD_SHIFT_WIDTH-1:0] o_rsp_headShift,
  output logic [META_SHIFT_WIDTH-1:0] o_rsp_metaShift,
  output logic [REP_VEC_W-1:0]        o_rsp_replaceOffset,
  input  logic                        i_cfg_wren,
  input  logic [IDX_W-1:0]            i_cfg_addr,
  input  logic                        i_cfg_valid,
  input  logic [TYPE_VEC_W-1:0]       i_cfg_typeData,
  input  logic [TYPE_VEC_W-1:0]       i_cfg_typeMask,
  input  logic [KEY_VEC_W-1:0]        i_cfg_keyOffset,
  input  logic [MERGE_VEC_W-1:0]      i_cfg_keyMergeOffset,
  input  logic [HEAD_SHIFT_WIDTH-1:0] i_cfg_headShift,
  input  logic [META_SHIFT_WIDTH-1:0] i_cfg_metaShift,
  output logic                        o_cfg_ack,
  input  logic                        i_cnt_clr,
  input  logic [CNT_AW-1:0]           i_cnt_rdAddr,
  output logic [CNT_WIDTH-1:0]        o_cnt_rdData,
  output cfg_state_t                  o_dbg_cfgState
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits on ready, and a stalled response holds all its fields.
  rule_t                 rules [RULE_NUM];
  rule_t                 new_rule;
  cfg_state_t            cfg_state, cfg_next;
  logic [RULE_NUM-1:0]   hit_vec, s1_hit, s1_onehot, sel;
  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_any, s1_valid, stall, req_fire, rsp_fire;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [KEY_VEC_W-1:0]        key_mux;
  logic [HEAD_SHIFT_WIDTH-1:0] head_mux;
  logic [META_SHIFT_WIDTH-1:0] meta_mux;
  logic [REP_VEC_W-1:0]        rep_mux;
  logic [CNT_WIDTH-1:0]  cnt [RULE_NUM+1];
  int                    cnt_sel;

  assign stall          = o_rsp_valid & ~i_rsp_ready;
  assign o_req_ready    = ~stall & (cfg_state == CFG_IDLE) & ~i_cfg_wren;
  assign req_fire       = i_req_valid & o_req_ready;
  assign rsp_fire       = o_rsp_valid & i_rsp_ready;
  assign o_cfg_ack      = (cfg_state == CFG_WRITE) & ~i_rst;
  assign o_dbg_cfgState = cfg_state;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      hit_vec[i] = rules[i].valid;
      for (int j = 0; j < TYPE_NUM; j++) begin
        if ((rules[i].type_mask[j*TYPE_WIDTH +: TYPE_WIDTH] & i_req_type[j*TYPE_WIDTH +: TYPE_WIDTH])
            != rules[i].type_data[j*TYPE_WIDTH +: TYPE_WIDTH])
          hit_vec[i] = 1'b0;
      end
    end
  end

  type_lookup_prio_enc #(.N(RULE_NUM), .IW(IDX_W)) u_enc (
    .hit    (s1_hit),
    .onehot (s1_onehot),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  // A miss leaves sel empty, so every payload field collapses to zero.
  always_comb begin
    sel      = (PRIORITY_MODE != 0) ? s1_onehot : s1_hit;
    key_mux  = '0;
    head_mux = '0;
    meta_mux = '0;
    rep_mux  = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      if (sel[i]) begin
        key_mux  = key_mux  | rules[i].key_offset;
        head_mux = head_mux | rules[i].head_shift;
        meta_mux = meta_mux | rules[i].meta_shift;
        rep_mux  = rep_mux  | rules[i].replace_offset;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid            <= 1'b0;
      s1_tag              <= '0;
      s1_hit              <= '0;
      o_rsp_valid         <= 1'b0;
      o_rsp_tag           <= '0;
      o_rsp_hit           <= 1'b0;
      o_rsp_ruleIdx       <= '0;
      o_rsp_keyOffset     <= '0;
      o_rsp_headShift     <= '0;
      o_rsp_metaShift     <= '0;
      o_rsp_replaceOffset <= '0;
    end else if (!stall) begin
      s1_valid <= req_fire;
      if (req_fire) begin
        s1_tag <= i_req_tag;
        s1_hit <= hit_vec;
      end
      o_rsp_valid <= s1_valid;
      if (s1_valid) begin
        o_rsp_tag           <= s1_tag;
        o_rsp_hit           <= enc_any;
        o_rsp_ruleIdx       <= enc_idx;
        o_rsp_keyOffset     <= key_mux;
        o_rsp_headShift     <= head_mux;
        o_rsp_metaShift     <= meta_mux;
        o_rsp_replaceOffset <= rep_mux;
      end
    end
  end

  always_comb begin
    new_rule                = '0;
    new_rule.valid          = i_cfg_valid;
    new_rule.type_data      = i_cfg_typeData;
    new_rule.type_mask      = i_cfg_typeMask;
    new_rule.key_offset     = i_cfg_keyOffset;
    new_rule.replace_offset = build_replace(i_cfg_keyOffset, i_cfg_keyMergeOffset);
    new_rule.head_shift     = i_cfg_headShift;
    new_rule.meta_shift     = i_cfg_metaShift;
  end

  // New lookups are blocked from DRAIN onward, so the table only changes with S1/S2 empty.
  always_comb begin
    cfg_next = cfg_state;
    case (cfg_state)
      CFG_IDLE:  if (i_cfg_wren) cfg_next = CFG_DRAIN;
      CFG_DRAIN: if (!s1_valid && !o_rsp_valid) cfg_next = CFG_WRITE;
      CFG_WRITE: cfg_next = CFG_IDLE;
      default:   cfg_next = CFG_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_state <= CFG_IDLE;
      for (int i = 0; i < RULE_NUM; i++) rules[i] <= '0;
    end else begin
      cfg_state <= cfg_next;
      if (cfg_state == CFG_WRITE && int'(i_cfg_addr) < RULE_NUM)
        rules[i_cfg_addr] <= new_rule;
    end
  end

  assign cnt_sel = o_rsp_hit ? int'(o_rsp_ruleIdx) : RULE_NUM;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i <= RULE_NUM; i++) cnt[i] <= '0;
      o_cnt_rdData <= '0;
    end else begin
      for (int i = 0; i <= RULE_NUM; i++) begin
        if (i_cnt_clr)
          cnt[i] <= '0;
        else if (rsp_fire && i == cnt_sel && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end
      o_cnt_rdData <= (int'(i_cnt_rdAddr) <= RULE_NUM) ? cnt[i_cnt_rdAddr] : '0;
    end
  end

endmodule

// File: tb/tb_type_lookup_pipe.sv
// Directed bench driving a priority-mode instance and an OR-mode, 4-bit-counter instance in lockstep.
module tb_type_lookup_pipe;
  import type_lookup_pkg::*;

  localparam int RN = 8;

  typedef struct packed {
    logic [7:0]  tag;
    logic        hit;
    logic [2:0]  idx;
    logic [55:0] key;
    logic [5:0]  hs;
    logic [5:0]  ms;
    logic [31:0] rep;
  } rsp_t;
  localparam int RSP_W = $bits(rsp_t);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, rsp_ready, cfg_wren, cfg_valid, cnt_clr;
  logic [63:0] req_type, cfg_data, cfg_mask;
  logic [7:0]  req_tag;
  logic [2:0]  cfg_addr;
  logic [55:0] cfg_key;
  logic [23:0] cfg_merge;
  logic [5:0]  cfg_hs, cfg_ms;
  logic [3:0]  cnt_addr;

  logic        p_req_ready, p_rsp_valid, p_hit, p_ack;
  logic [7:0]  p_tag;
  logic [2:0]  p_idx;
  logic [55:0] p_key;
  logic [5:0]  p_hs, p_ms;
  logic [31:0] p_rep, p_cnt;
  cfg_state_t  p_state;

  logic        x_req_ready, x_rsp_valid, x_hit, x_ack;
  logic [7:0]  x_tag;
  logic [2:0]  x_idx;
  logic [55:0] x_key;
  logic [5:0]  x_hs, x_ms;
  logic [31:0] x_rep;
  logic [3:0]  x_cnt;
  cfg_state_t  x_state;

  int n_checks = 0;
  int n_bad    = 0;
  logic [RSP_W-1:0] exp_q[$];
  logic [RSP_W-1:0] exp_x_q[$];

  logic        m_valid [RN];
  logic [63:0] m_data  [RN];
  logic [63:0] m_mask  [RN];
  logic [55:0] m_key   [RN];
  logic [31:0] m_rep   [RN];
  logic [5:0]  m_hs    [RN];
  logic [5:0]  m_ms    [RN];

  type_lookup_pipe #(.RULE_NUM(RN), .TAG_WIDTH(8), .CNT_WIDTH(32), .PRIORITY_MODE(1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(p_req_ready),
    .i_req_type(req_type), .i_req_tag(req_tag), .o_rsp_valid(p_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_tag(p_tag), .o_rsp_hit(p_hit), .o_rsp_ruleIdx(p_idx), .o_rsp_keyOffset(p_key),
    .o_rsp_headShift(p_hs), .o_rsp_metaShift(p_ms), .o_rsp_replaceOffset(p_rep),
    .i_cfg_wren(cfg_wren), .i_cfg_addr(cfg_addr), .i_cfg_valid(cfg_valid),
    .i_cfg_typeData(cfg_data), .i_cfg_typeMask(cfg_mask), .i_cfg_keyOffset(cfg_key),
    .i_cfg_keyMergeOffset(cfg_merge), .i_cfg_headShift(cfg_hs), .i_cfg_metaShift(cfg_ms),
    .o_cfg_ack(p_ack), .i_cnt_clr(cnt_clr), .i_cnt_rdAddr(cnt_addr), .o_cnt_rdData(p_cnt),
    .o_dbg_cfgState(p_state)
  );

  type_lookup_pipe #(.RULE_NUM(RN), .TAG_WIDTH(8), .CNT_WIDTH(4), .PRIORITY_MODE(0)) dut_x (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(x_req_ready),
    .i_req_type(req_type), .i_req_tag(req_tag), .o_rsp_valid(x_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_tag(x_tag), .o_rsp_hit(x_hit), .o_rsp_ruleIdx(x_idx), .o_rsp_keyOffset(x_key),
    .o_rsp_headShift(x_hs), .o_rsp_metaShift(x_ms), .o_rsp_replaceOffset(x_rep),
    .i_cfg_wren(cfg_wren), .i_cfg_addr(cfg_addr), .i_cfg_valid(cfg_valid),
    .i_cfg_typeData(cfg_data), .i_cfg_typeMask(cfg_mask), .i_cfg_keyOffset(cfg_key),
    .i_cfg_keyMergeOffset(cfg_merge), .i_cfg_headShift(cfg_hs), .i_cfg_metaShift(cfg_ms),
    .o_cfg_ack(x_ack), .i_cnt_clr(cnt_clr), .i_cnt_rdAddr(cnt_addr), .o_cnt_rdData(x_cnt),
    .o_dbg_cfgState(x_state)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic rsp_t model(input logic [63:0] ty, input logic [7:0] tag, input bit prio);
    rsp_t r;
    bit found, m;
    r = '0;
    r.tag = tag;
    found = 1'b0;
    for (int i = 0; i < RN; i++) begin
      m = m_valid[i];
      for (int j = 0; j < 4; j++)
        if ((m_mask[i][j*16 +: 16] & ty[j*16 +: 16]) != m_data[i][j*16 +: 16]) m = 1'b0;
      if (m) begin
        if (!found) begin
          r.hit = 1'b1;
          r.idx = 3'(i);
        end
        if (!prio || !found) begin
          r.key = r.key | m_key[i];
          r.hs  = r.hs  | m_hs[i];
          r.ms  = r.ms  | m_ms[i];
          r.rep = r.rep | m_rep[i];
        end
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Responses are compared against the queue head every cycle they are valid, stalled or not.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (p_rsp_valid) begin
        if (exp_q.size() == 0) check("p_unexpected_rsp", 128'(exp_q.size()), 128'd1);
        else begin
          e = rsp_t'(exp_q[0]);
          check("p_tag", p_tag, e.tag);
          check("p_hit_idx", {p_hit, p_idx}, {e.hit, e.idx});
          check("p_key", p_key, e.key);
          check("p_shift", {p_hs, p_ms}, {e.hs, e.ms});
          check("p_rep", p_rep, e.rep);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (x_rsp_valid) begin
        if (exp_x_q.size() == 0) check("x_unexpected_rsp", 128'(exp_x_q.size()), 128'd1);
        else begin
          e = rsp_t'(exp_x_q[0]);
          check("x_tag", x_tag, e.tag);
          check("x_hit_idx", {x_hit, x_idx}, {e.hit, e.idx});
          check("x_key", x_key, e.key);
          check("x_shift", {x_hs, x_ms}, {e.hs, e.ms});
          check("x_rep", x_rep, e.rep);
          if (rsp_ready) void'(exp_x_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [63:0] ty, input logic [7:0] tag);
    int n;
    req_valid = 1'b1;
    req_type  = ty;
    req_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!p_req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("req_accept_bound", 128'(n < 100), 128'd1);
    check("x_req_ready", x_req_ready, 1'b1);
    exp_q.push_back(model(ty, tag, 1'b1));
    exp_x_q.push_back(model(ty, tag, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_x_q.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_bound", 128'(n < 100), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic write_rule(input logic [2:0] addr, input logic vld, input logic [63:0] data,
                            input logic [63:0] mask, input logic [55:0] key, input logic [23:0] merge,
                            input logic [5:0] hs, input logic [5:0] ms, input int exp_lat);
    int n, c;
    logic [31:0] rep;
    cfg_addr = addr; cfg_valid = vld; cfg_data = data; cfg_mask = mask;
    cfg_key = key; cfg_merge = merge; cfg_hs = hs; cfg_ms = ms;
    cfg_wren = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (p_ack) break;
      check("cfg_req_ready_low", p_req_ready, 1'b0);
    end
    check("ack_latency", 128'(n - 1), 128'(exp_lat));
    check("x_ack", x_ack, 1'b1);
    rep = '0;
    for (int k = 0; k < 8; k++) begin
      c = int'(merge[k*3 +: 3]);
      rep[c*4 +: 4] = rep[c*4 +: 4] | {key[k*7 + 6], 3'(k)};
    end
    m_valid[addr] = vld; m_data[addr] = data; m_mask[addr] = mask; m_key[addr] = key;
    m_rep[addr] = rep; m_hs[addr] = hs; m_ms[addr] = ms;
    @(posedge clk);
    #1;
    cfg_wren = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", p_ack, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_cnt(input logic [3:0] addr, input logic [31:0] exp_p, input logic [3:0] exp_x);
    cnt_addr = addr;
    @(posedge clk);
    @(negedge clk);
    check("cnt_p", p_cnt, exp_p);
    check("cnt_x", x_cnt, exp_x);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] rand_key();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] k2;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; cfg_wren = 1'b0; cfg_valid = 1'b0;
    cnt_clr = 1'b0; req_type = '0; req_tag = '0; cfg_data = '0; cfg_mask = '0; cfg_addr = '0;
    cfg_key = '0; cfg_merge = '0; cfg_hs = '0; cfg_ms = '0; cnt_addr = '0;
    for (int i = 0; i < RN; i++) begin
      m_valid[i] = 0; m_data[i] = '0; m_mask[i] = '0; m_key[i] = '0;
      m_rep[i] = '0; m_hs[i] = '0; m_ms[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {p_rsp_valid, x_rsp_valid}, 2'b00);
    check("rst_ack", {p_ack, x_ack}, 2'b00);
    check("rst_cnt", p_cnt, 32'd0);
    check("rst_outputs", {p_tag, p_hit, p_idx, p_key, p_hs, p_ms, p_rep}, '0);
    check("rst_state", p_state, CFG_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // no rule valid: three misses
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 8'(i + 1));
    req_valid = 1'b0;
    drain();
    read_cnt(4'd8, 32'd3, 4'd3);

    // single rule on field 0, empty pipeline write
    k2 = rand_key();
    k2[6:0] = 7'h45;
    write_rule(3'd2, 1'b1, 64'h0800, 64'hFFFF, k2, 24'($urandom_range(0, 24'hFFFFFF)),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 2);
    send(64'h0800, 8'hA5);
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_s1_empty", {p_rsp_valid, x_rsp_valid}, 2'b00);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_s2_valid", {p_rsp_valid, x_rsp_valid}, 2'b11);
    check("t2_direct", {p_hit, p_idx, p_key[6:0], p_tag}, {1'b1, 3'd2, 7'h45, 8'hA5});
    drain();
    read_cnt(4'd2, 32'd1, 4'd1);

    // rules 1 and 3 both hit on field 1
    write_rule(3'd1, 1'b1, 64'h1234_0000, 64'hFFFF_0000, rand_key(),
               24'($urandom_range(0, 24'hFFFFFF)), 6'h05, 6'($urandom_range(0, 63)), 2);
    write_rule(3'd3, 1'b1, 64'h0034_0000, 64'h00FF_0000, rand_key(),
               24'($urandom_range(0, 24'hFFFFFF)), 6'h12, 6'($urandom_range(0, 63)), 2);
    send(64'h1234_0000, 8'h77);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_prio", {p_idx, p_hs}, {3'd1, 6'h05});
    check("t3_or", {x_idx, x_hs}, {3'd1, 6'h17});
    drain();

    // back-to-back with three stalled cycles after the first response
    send(64'h0800, 8'h10);
    send(64'h1234_0000, 8'h11);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_type  = 64'h0034_0000;
    req_tag   = 8'h12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready_low", {p_req_ready, p_rsp_valid}, 2'b01);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    send(64'h0034_0000, 8'h12);
    send({$urandom, $urandom}, 8'h13);
    req_valid = 1'b0;
    drain();

    // rule rewrite with two lookups in flight
    send(64'h86DD, 8'h20);
    send(64'h0800, 8'h21);
    req_valid = 1'b0;
    write_rule(3'd2, 1'b1, 64'h86DD, 64'hFFFF, rand_key(), 24'($urandom_range(0, 24'hFFFFFF)),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 3);
    send(64'h86DD, 8'h22);
    send(64'h0800, 8'h23);
    req_valid = 1'b0;
    drain();

    // counter clear coinciding with a hit handshake
    send(64'h86DD, 8'h30);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    drain();
    read_cnt(4'd2, 32'd0, 4'd0);
    read_cnt(4'd8, 32'd0, 4'd0);

    // 20 misses: 4-bit counter saturates
    for (int i = 0; i < 20; i++) send(64'hFFFF_0000, 8'(8'h50 + i));
    req_valid = 1'b0;
    drain();
    read_cnt(4'd8, 32'd20, 4'hF);

    // reset while a response sits in S2
    send(64'h86DD, 8'h40);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_s2_valid", {p_rsp_valid, x_rsp_valid}, 2'b00);
    check("rst_s2_ack", p_ack, 1'b0);
    check("rst_s2_state", p_state, CFG_IDLE);
    exp_q.delete();
    exp_x_q.delete();
    for (int i = 0; i < RN; i++) m_valid[i] = 1'b0;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    read_cnt(4'd8, 32'd0, 4'd0);
    send(64'h86DD, 8'h41);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_miss", {p_rsp_valid, p_hit, p_idx}, {1'b1, 1'b0, 3'd0});
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
